// File: rtl/i2s_rx.sv
// I2S serial audio receiver: oversamples bclk/lrck/din in the clk32 domain and
// emits 16-bit stereo pairs. Optional counters enabled by I2S_RX_STATS_EN.
module i2s_rx #(
  parameter int I2S_DELAY   = 0,
  parameter int SAMPLE_FALL = 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic               clk32,
  input  logic               reset,
  input  logic               i2s_bclk,
  input  logic               i2s_lrck,
  input  logic               i2s_din,
  output logic signed [15:0] audio_l,
  output logic signed [15:0] audio_r,
  output logic               audio_valid,
  output logic               locked,
  output logic               frame_err
`ifdef I2S_RX_STATS_EN
  ,
  output logic        [15:0] frame_cnt,
  output logic        [7:0]  err_cnt
`endif
);

  localparam logic [4:0]  FIRST_IDX = 5'(I2S_DELAY);
  localparam logic [4:0]  LAST_IDX  = 5'(I2S_DELAY + 15);
  localparam logic [15:0] TO_LIMIT  = 16'(TIMEOUT);

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  logic [2:0] sync_p0, sync_p1, sync_p2;

  // Stage p0..p2: {bclk, lrck, din} synchronizer plus history
  always_ff @(posedge clk32) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p0 <= {i2s_bclk, i2s_lrck, i2s_din};
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  logic        smp_edge, lrck_s, din_s, boundary, in_word;
  logic [4:0]  idx;
  logic [15:0] word_next;

  logic               prev_lrck, armed, done, left_ok;
  logic [4:0]         bit_cnt;
  logic [14:0]        shreg;
  logic signed [15:0] left_hold;
  logic [15:0]        to_cnt;

  // Data is taken from the history stage so it is stable across the detected edge
  assign smp_edge  = (SAMPLE_FALL != 0) ? (sync_p2[2] & ~sync_p1[2])
                                        : (~sync_p2[2] & sync_p1[2]);
  assign lrck_s    = sync_p2[1];
  assign din_s     = sync_p2[0];
  assign boundary  = (lrck_s != prev_lrck);
  assign idx       = boundary ? 5'd0 : sat_inc5(bit_cnt);
  assign in_word   = ((idx - FIRST_IDX) < 5'd16);
  assign word_next = boundary ? {15'd0, din_s} : {shreg, din_s};

  // Sampling-edge stage: word assembly, channel pairing, error and timeout tracking
  always_ff @(posedge clk32) begin
    if (reset) begin
      prev_lrck   <= 1'b0;
      armed       <= 1'b1;
      done        <= 1'b0;
      left_ok     <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      left_hold   <= '0;
      to_cnt      <= '0;
      audio_l     <= '0;
      audio_r     <= '0;
      audio_valid <= 1'b0;
      locked      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (smp_edge) begin
        to_cnt    <= '0;
        prev_lrck <= lrck_s;
        bit_cnt   <= idx;
        if (in_word)
          shreg <= word_next[14:0];
        if (boundary) begin
          done <= 1'b0;
          if (armed) begin
            armed <= 1'b0;
          end else if (!done) begin
            frame_err <= 1'b1;
            locked    <= 1'b0;
            left_ok   <= 1'b0;
          end
        end
        // The last word bit never coincides with a boundary, so armed is current here
        if (idx == LAST_IDX && !armed) begin
          done <= 1'b1;
          if (!lrck_s) begin
            left_hold <= word_next;
            left_ok   <= 1'b1;
          end else if (left_ok) begin
            audio_l     <= left_hold;
            audio_r     <= word_next;
            audio_valid <= 1'b1;
            locked      <= 1'b1;
            left_ok     <= 1'b0;
          end
        end
      end else if (to_cnt != TO_LIMIT) begin
        to_cnt <= to_cnt + 16'd1;
        if (to_cnt == TO_LIMIT - 16'd1) begin
          frame_err <= 1'b1;
          locked    <= 1'b0;
          left_ok   <= 1'b0;
          bit_cnt   <= '0;
          armed     <= 1'b1;
          done      <= 1'b0;
        end
      end
    end
  end

`ifdef I2S_RX_STATS_EN
  always_ff @(posedge clk32) begin
    if (reset) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (audio_valid)
        frame_cnt <= frame_cnt + 16'd1;
      if (frame_err && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S channels and checks against a channel-level model.
`timescale 1ns/1ps
module tb_i2s_rx;
  localparam realtime HALF = 325.5;

  logic clk32 = 1'b0;
  logic reset = 1'b1;
  logic bclk = 1'b0, lrck = 1'b0, din = 1'b0;
  logic [15:0] audio_l, audio_r, ph_audio_l, ph_audio_r;
  logic audio_valid, locked, frame_err;
  logic ph_valid, ph_locked, ph_err;
`ifdef I2S_RX_STATS_EN
  logic [15:0] fc0, fc1;
  logic [7:0]  ec0, ec1;
`endif

  always #15.625 clk32 = ~clk32;

  i2s_rx dut (
    .clk32(clk32), .reset(reset), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_din(din),
    .audio_l(audio_l), .audio_r(audio_r), .audio_valid(audio_valid),
    .locked(locked), .frame_err(frame_err)
`ifdef I2S_RX_STATS_EN
    , .frame_cnt(fc0), .err_cnt(ec0)
`endif
  );

  i2s_rx #(.I2S_DELAY(1)) dut_ph (
    .clk32(clk32), .reset(reset), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_din(din),
    .audio_l(ph_audio_l), .audio_r(ph_audio_r), .audio_valid(ph_valid),
    .locked(ph_locked), .frame_err(ph_err)
`ifdef I2S_RX_STATS_EN
    , .frame_cnt(fc1), .err_cnt(ec1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_fall = 0;

  logic [15:0] obs_l[$], obs_r[$], pho_l[$], pho_r[$];
  int err_q[$];
  int ph_errs;

  always @(negedge clk32) begin
    cyc++;
    if (audio_valid) begin obs_l.push_back(audio_l); obs_r.push_back(audio_r); end
    if (ph_valid)    begin pho_l.push_back(ph_audio_l); pho_r.push_back(ph_audio_r); end
    if (frame_err) err_q.push_back(cyc);
    if (ph_err) ph_errs++;
  end

  // Channel-level reference model
  int          m_d;
  logic        m_prev, m_armed, m_done, m_left_ok, m_locked;
  logic [15:0] m_left_hold, m_al, m_ar;
  int          m_err;
  logic [15:0] exp_l[$], exp_r[$];

  function automatic void model_reset(input int d);
    m_d = d; m_prev = 1'b0; m_armed = 1'b1; m_done = 1'b0;
    m_left_ok = 1'b0; m_locked = 1'b0; m_err = 0;
    m_al = 16'h0; m_ar = 16'h0; m_left_hold = 16'h0;
    exp_l.delete(); exp_r.delete();
  endfunction

  function automatic void model_chan(input logic lr, input logic [31:0] bits, input int n);
    logic [15:0] w;
    if (lr != m_prev) begin
      if (m_armed) m_armed = 1'b0;
      else if (!m_done) begin m_err++; m_locked = 1'b0; m_left_ok = 1'b0; end
    end
    m_prev = lr;
    m_done = 1'b0;
    if (!m_armed && n >= m_d + 16) begin
      m_done = 1'b1;
      w = bits[31 - m_d -: 16];
      if (!lr) begin
        m_left_hold = w; m_left_ok = 1'b1;
      end else if (m_left_ok) begin
        exp_l.push_back(m_left_hold); exp_r.push_back(w);
        m_al = m_left_hold; m_ar = w; m_locked = 1'b1; m_left_ok = 1'b0;
      end
    end
  endfunction

  function automatic void model_timeout();
    m_err++; m_locked = 1'b0; m_left_ok = 1'b0; m_armed = 1'b1; m_done = 1'b0;
  endfunction

  task automatic send_chan(input logic lr, input logic [31:0] bits, input int n, input bit upd);
    for (int i = 0; i < n; i++) begin
      bclk = 1'b1; lrck = lr; din = bits[31 - i];
      #(HALF);
      bclk = 1'b0; last_fall = cyc;
      #(HALF);
    end
    if (upd) model_chan(lr, bits, n);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int slot);
    send_chan(1'b0, {l, 16'($urandom)}, slot, 1'b1);
    send_chan(1'b1, {r, 16'($urandom)}, slot, 1'b1);
  endtask

  task automatic do_reset(input int d);
    @(negedge clk32); reset = 1'b1;
    repeat (2) @(negedge clk32);
    reset = 1'b0;
    obs_l.delete(); obs_r.delete(); pho_l.delete(); pho_r.delete();
    err_q.delete(); ph_errs = 0;
    model_reset(d);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk32);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk32);
    n_checks++; if (audio_l !== 16'h0) begin n_fail++; $display("FAIL reset_audio_l got %h want 0000", audio_l); end
    n_checks++; if (audio_r !== 16'h0) begin n_fail++; $display("FAIL reset_audio_r got %h want 0000", audio_r); end
    n_checks++; if (audio_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", audio_valid); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
  endtask

  task automatic test_basic();
    do_reset(0);
    send_frame(16'h1111, 16'h2222, 32);
    settle();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL basic_prelock got %b want 0", locked); end
    n_checks++; if (obs_l.size() != 0) begin n_fail++; $display("FAIL basic_prevalid got %0d want 0", obs_l.size()); end
    send_frame(16'h1234, 16'hABCD, 32);
    settle();
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL basic_lock got %b want 1", locked); end
    repeat (4) send_frame(16'h1234, 16'hABCD, 32);
    settle();
    n_checks++; if (obs_l.size() != exp_l.size()) begin n_fail++; $display("FAIL basic_count got %0d want %0d", obs_l.size(), exp_l.size()); end
    for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++) begin
      n_checks++;
      if ({obs_l[i], obs_r[i]} !== {exp_l[i], exp_r[i]}) begin
        n_fail++; $display("FAIL basic_pair%0d got %h/%h want %h/%h", i, obs_l[i], obs_r[i], exp_l[i], exp_r[i]);
      end
    end
    n_checks++; if (err_q.size() != m_err) begin n_fail++; $display("FAIL basic_errs got %0d want %0d", err_q.size(), m_err); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] l, r;
    do_reset(0);
    send_frame(16'h0F0F, 16'hF0F0, 32);
    send_frame(16'h1357, 16'h2468, 32);
    fork
      send_chan(1'b0, {16'h7777, 16'h0}, 32, 1'b0);
      begin
        #(HALF * 16);
        @(negedge clk32); reset = 1'b1;
        @(negedge clk32);
        n_checks++; if ({audio_l, audio_r} !== 32'h0) begin n_fail++; $display("FAIL midrst_audio got %h/%h want 0/0", audio_l, audio_r); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked got %b want 0", locked); end
        @(negedge clk32); reset = 1'b0;
        obs_l.delete(); obs_r.delete(); err_q.delete();
        model_reset(0);
      end
    join
    model_chan(1'b0, {16'h7777, 16'h0}, 32);
    send_chan(1'b1, {16'h8888, 16'h0}, 32, 1'b1);
    settle();
    n_checks++; if (obs_l.size() != 0 || locked !== 1'b0) begin n_fail++; $display("FAIL midrst_novalid got %0d/%b want 0/0", obs_l.size(), locked); end
    l = 16'($urandom); r = 16'($urandom);
    send_frame(l, r, 32);
    settle();
    n_checks++; if (obs_l.size() != 1) begin n_fail++; $display("FAIL midrst_count got %0d want 1", obs_l.size()); end
    else begin
      n_checks++; if ({obs_l[0], obs_r[0]} !== {l, r}) begin n_fail++; $display("FAIL midrst_pair got %h/%h want %h/%h", obs_l[0], obs_r[0], l, r); end
    end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL midrst_lock got %b want 1", locked); end
  endtask

  task automatic test_short_channel();
    int nv;
    do_reset(0);
    send_frame(16'h1111, 16'h2222, 32);
    send_frame(16'h3333, 16'h4444, 32);
    nv = obs_l.size();
    send_chan(1'b0, {16'h5555, 16'h0}, 10, 1'b1);
    send_chan(1'b1, {16'h6666, 16'h0}, 32, 1'b1);
    settle();
    n_checks++; if (err_q.size() != 1 || m_err != 1) begin n_fail++; $display("FAIL short_err got %0d want 1 (model %0d)", err_q.size(), m_err); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL short_locked got %b want 0", locked); end
    n_checks++; if (obs_l.size() != nv) begin n_fail++; $display("FAIL short_novalid got %0d want %0d", obs_l.size(), nv); end
    send_frame(16'h7777, 16'h8888, 32);
    settle();
    n_checks++; if (locked !== m_locked) begin n_fail++; $display("FAIL short_relock got %b want %b", locked, m_locked); end
    n_checks++; if (obs_l.size() != exp_l.size()) begin n_fail++; $display("FAIL short_count got %0d want %0d", obs_l.size(), exp_l.size()); end
    else begin
      n_checks++; if ({obs_l[$], obs_r[$]} !== {exp_l[$], exp_r[$]}) begin n_fail++; $display("FAIL short_resume got %h/%h want %h/%h", obs_l[$], obs_r[$], exp_l[$], exp_r[$]); end
    end
  endtask

  task automatic test_wide_slots();
    do_reset(0);
    send_chan(1'b0, {24'h8001AA, 8'h00}, 24, 1'b1);
    send_chan(1'b1, {24'h7FFE55, 8'h00}, 24, 1'b1);
    repeat (3) begin
      send_chan(1'b0, {24'h8001AA, 8'h00}, 24, 1'b1);
      send_chan(1'b1, {24'h7FFE55, 8'h00}, 24, 1'b1);
    end
    settle();
    n_checks++; if (obs_l.size() != 3) begin n_fail++; $display("FAIL wide_count got %0d want 3", obs_l.size()); end
    for (int i = 0; i < obs_l.size(); i++) begin
      n_checks++;
      if ({obs_l[i], obs_r[i]} !== {16'h8001, 16'h7FFE}) begin
        n_fail++; $display("FAIL wide_pair%0d got %h/%h want 8001/7ffe", i, obs_l[i], obs_r[i]);
      end
    end
    n_checks++; if (err_q.size() != 0) begin n_fail++; $display("FAIL wide_errs got %0d want 0", err_q.size()); end
  endtask

  task automatic test_random();
    int slot;
    do_reset(0);
    send_frame(16'($urandom), 16'($urandom), 32);
    for (int f = 0; f < 8; f++) begin
      slot = 16 + 8 * $urandom_range(0, 2);
      send_frame(16'($urandom), 16'($urandom), slot);
    end
    settle();
    n_checks++; if (obs_l.size() != exp_l.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", obs_l.size(), exp_l.size()); end
    for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++) begin
      n_checks++;
      if ({obs_l[i], obs_r[i]} !== {exp_l[i], exp_r[i]}) begin
        n_fail++; $display("FAIL rand_pair%0d got %h/%h want %h/%h", i, obs_l[i], obs_r[i], exp_l[i], exp_r[i]);
      end
    end
    n_checks++; if (locked !== m_locked) begin n_fail++; $display("FAIL rand_locked got %b want %b", locked, m_locked); end
  endtask

  task automatic test_timeout();
    int dly, nv;
    do_reset(0);
    send_frame(16'($urandom), 16'($urandom), 32);
    send_frame(16'($urandom), 16'($urandom), 32);
    send_frame(16'($urandom), 16'($urandom), 32);
    repeat (1100) @(negedge clk32);
    model_timeout();
    n_checks++; if (err_q.size() != 1) begin n_fail++; $display("FAIL timeout_pulses got %0d want 1", err_q.size()); end
    else begin
      dly = err_q[0] - last_fall;
      n_checks++; if (dly < 1024 || dly > 1032) begin n_fail++; $display("FAIL timeout_delay got %0d want 1024..1032", dly); end
    end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL timeout_locked got %b want 0", locked); end
    n_checks++; if ({audio_l, audio_r} !== {m_al, m_ar}) begin n_fail++; $display("FAIL timeout_hold got %h/%h want %h/%h", audio_l, audio_r, m_al, m_ar); end
    nv = obs_l.size();
    send_frame(16'hA5A5, 16'h5A5A, 32);
    settle();
    n_checks++; if (obs_l.size() != exp_l.size() || obs_l.size() != nv + 1) begin n_fail++; $display("FAIL timeout_rearm got %0d want %0d", obs_l.size(), exp_l.size()); end
    n_checks++; if (err_q.size() != m_err) begin n_fail++; $display("FAIL timeout_errs got %0d want %0d", err_q.size(), m_err); end
  endtask

  task automatic test_philips();
    do_reset(1);
    send_chan(1'b0, {1'($urandom), 16'h1111, 15'($urandom)}, 32, 1'b1);
    send_chan(1'b1, {1'($urandom), 16'h2222, 15'($urandom)}, 32, 1'b1);
    repeat (10) begin
      send_chan(1'b0, {1'($urandom), 16'h5A5A, 15'($urandom)}, 32, 1'b1);
      send_chan(1'b1, {1'($urandom), 16'hC3C3, 15'($urandom)}, 32, 1'b1);
    end
    settle();
    n_checks++; if (pho_l.size() != 10 || exp_l.size() != 10) begin n_fail++; $display("FAIL ph_count got %0d want 10", pho_l.size()); end
    for (int i = 0; i < pho_l.size(); i++) begin
      n_checks++;
      if ({pho_l[i], pho_r[i]} !== {16'h5A5A, 16'hC3C3}) begin
        n_fail++; $display("FAIL ph_pair%0d got %h/%h want 5a5a/c3c3", i, pho_l[i], pho_r[i]);
      end
    end
    n_checks++; if (ph_errs != 0) begin n_fail++; $display("FAIL ph_errs got %0d want 0", ph_errs); end
    n_checks++; if (ph_locked !== 1'b1) begin n_fail++; $display("FAIL ph_locked got %b want 1", ph_locked); end
`ifdef I2S_RX_STATS_EN
    n_checks++; if (fc1 !== 16'd10) begin n_fail++; $display("FAIL ph_frame_cnt got %0d want 10", fc1); end
    n_checks++; if (ec1 !== 8'd0) begin n_fail++; $display("FAIL ph_err_cnt got %0d want 0", ec1); end
`endif
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset(0);
    test_reset();
    test_basic();
    test_reset_midframe();
    test_short_channel();
    test_wide_slots();
    test_random();
    test_timeout();
    test_philips();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
